// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial front end feeding an overlapping 11011 Mealy detector.
// Defining SERIAL_BIT_FEEDER_GAPLESS_EN adds a one-word holding register so back-to-back words stream gaplessly.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             y,
  output logic             y_valid,
  output logic             last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt, w_load_word, w_shifted;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic r_y, r_y_valid, r_last, r_busy;
  logic w_y_nxt, w_y_valid_nxt, w_last_nxt, w_busy_nxt;
  logic w_xfer, w_last_bit, w_load, w_hold_full_nxt;
  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction
  assign w_xfer     = din_valid && din_ready;
  assign w_last_bit = (r_state == SHIFT) && (r_cnt == LAST_CNT);
  assign w_shifted  = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
`ifdef SERIAL_BIT_FEEDER_GAPLESS_EN
  logic [WIDTH-1:0] r_hold;
  logic r_hold_full;
  assign din_ready       = !r_hold_full;
  assign w_load          = r_hold_full && (r_state == IDLE || w_last_bit);
  assign w_load_word     = r_hold;
  assign w_hold_full_nxt = w_xfer || (r_hold_full && !w_load);
  // holding register captures every accepted word until the shifter drains it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_xfer) r_hold <= din;
      r_hold_full <= w_hold_full_nxt;
    end
`else
  assign din_ready       = (r_state == IDLE);
  assign w_load          = w_xfer;
  assign w_load_word     = din;
  assign w_hold_full_nxt = 1'b0;
`endif
  // shifter state register; reset discards any partial word
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // leave SHIFT only on the last bit, and only when no word is ready to reload
  always_comb
    w_state_nxt = (r_state == IDLE || w_last_bit) ? (w_load ? SHIFT : IDLE) : SHIFT;
  // next shift register, bit count and registered outputs
  always_comb begin
    w_sreg_nxt    = w_load ? w_load_word : (r_state == SHIFT ? w_shifted : r_sreg);
    w_cnt_nxt     = (w_state_nxt == SHIFT && !w_load) ? r_cnt + CW'(1) : '0;
    w_y_valid_nxt = (w_state_nxt == SHIFT);
    w_y_nxt       = w_y_valid_nxt && head(w_sreg_nxt);
    w_last_nxt    = w_y_valid_nxt && (w_cnt_nxt == LAST_CNT);
    w_busy_nxt    = w_y_valid_nxt || w_hold_full_nxt;
  end
  // datapath and output registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sreg    <= '0;
      r_cnt     <= '0;
      r_y       <= 1'b0;
      r_y_valid <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sreg    <= w_sreg_nxt;
      r_cnt     <= w_cnt_nxt;
      r_y       <= w_y_nxt;
      r_y_valid <= w_y_valid_nxt;
      r_last    <= w_last_nxt;
      r_busy    <= w_busy_nxt;
    end
  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign last    = r_last;
  assign busy    = r_busy;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: directed self-checking bench for serial_bit_feeder (base or gapless build).
module tb_serial_bit_feeder;
`ifdef SERIAL_BIT_FEEDER_GAPLESS_EN
  localparam bit GAPLESS = 1'b1;
`else
  localparam bit GAPLESS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] din_m = '0, din_l = '0;
  logic dv_m = 1'b0, dv_l = 1'b0;
  logic rdy_m, y_m, yv_m, last_m, busy_m;
  logic rdy_l, y_l, yv_l, last_l, busy_l;
  logic sel = 1'b0;
  logic oy, oyv, olast, ordy, obusy;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .din(din_m), .din_valid(dv_m), .din_ready(rdy_m),
    .y(y_m), .y_valid(yv_m), .last(last_m), .busy(busy_m)
  );
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(dv_l), .din_ready(rdy_l),
    .y(y_l), .y_valid(yv_l), .last(last_l), .busy(busy_l)
  );
  assign oy    = sel ? y_l : y_m;
  assign oyv   = sel ? yv_l : yv_m;
  assign olast = sel ? last_l : last_m;
  assign ordy  = sel ? rdy_l : rdy_m;
  assign obusy = sel ? busy_l : busy_m;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_word(input logic lsb, input logic [7:0] w, input logic [7:0] zmask, input string tag);
    logic [4:0] hist;
    logic zv;
    logic eb;
    sel = lsb;
    hist = '0;
    if (lsb) begin din_l = w; dv_l = 1'b1; end
    else begin din_m = w; dv_m = 1'b1; end
    check({tag, "_rdy_before"}, ordy, 1);
    tick();
    dv_l = 1'b0;
    dv_m = 1'b0;
`ifdef SERIAL_BIT_FEEDER_GAPLESS_EN
    check({tag, "_held"}, {oy, oyv, obusy, ordy}, 4'b0010);
    tick();
`endif
    for (int k = 0; k < 8; k++) begin
      eb = lsb ? w[k] : w[7-k];
      zv = ({hist[3:0], oy} == 5'b11011);
      check($sformatf("%s_bit%0d", tag, k), {oy, oyv, olast, ordy, obusy},
            {eb, 1'b1, (k == 7), GAPLESS, 1'b1});
      check($sformatf("%s_z%0d", tag, k), zv, zmask[k]);
      hist = {hist[3:0], oy};
      tick();
    end
    check({tag, "_idle_after"}, {oy, oyv, olast, ordy, obusy}, 5'b00010);
  endtask
  task automatic stream(input logic [31:0] ws, input int nw, input int ncyc, output logic [63:0] got,
                        output int nbits, output int gaps, output int zcnt, output int zidx, output int lerr,
                        output int naccepted);
    logic [4:0] hist;
    logic zv, acc, seen;
    logic [31:0] sh;
    int pend;
    sel = 1'b0;
    hist = '0; got = '0; nbits = 0; gaps = 0; zcnt = 0; zidx = 0; lerr = 0; naccepted = 0;
    seen = 1'b0; pend = 0;
    for (int c = 0; c < ncyc; c++) begin
      dv_m = (naccepted < nw);
      if (naccepted < nw) begin
        sh = ws >> (8 * (nw - 1 - naccepted));
        din_m = sh[7:0];
      end
      acc = dv_m && rdy_m;
      tick();
      if (acc) naccepted++;
      zv = ({hist[3:0], y_m} == 5'b11011);
      if (zv) begin
        zcnt++;
        zidx = nbits + 1;
      end
      if (yv_m) begin
        got = {got[62:0], y_m};
        if (last_m != (nbits % 8 == 7)) lerr++;
        if (seen) gaps += pend;
        pend = 0;
        seen = 1'b1;
        nbits++;
      end else begin
        if (last_m || y_m) lerr++;
        if (seen) pend++;
      end
      hist = {hist[3:0], y_m};
    end
    dv_m = 1'b0;
  endtask
  initial begin
    logic [63:0] got;
    int nbits, gaps, zcnt, zidx, lerr, nacc;
    tick();
    check("rst_held", {y_m, yv_m, last_m, busy_m, rdy_m}, 5'b00001);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("idle%0d", i), {y_m, yv_m, last_m, busy_m, rdy_m}, 5'b00001);
    end
    run_word(1'b0, 8'hDB, 8'b1001_0000, "msb_db");
    tick();
    run_word(1'b1, 8'h01, 8'h00, "lsb_01");
    tick();
    stream(32'h0000_0360, 2, 30, got, nbits, gaps, zcnt, zidx, lerr, nacc);
    check("x_accepted", nacc, 2);
    check("x_bits", got[15:0], 16'h0360);
    check("x_nbits", nbits, 16);
    check("x_gaps", gaps, GAPLESS ? 0 : 1);
    check("x_zcnt", zcnt, GAPLESS ? 1 : 0);
    check("x_zidx", zidx, GAPLESS ? 11 : 0);
    check("x_last", lerr, 0);
    stream(32'h00A5_3CF0, 3, 40, got, nbits, gaps, zcnt, zidx, lerr, nacc);
    check("b2b_accepted", nacc, 3);
    check("b2b_bits", got[23:0], 24'hA53CF0);
    check("b2b_nbits", nbits, 24);
    check("b2b_gaps", gaps, GAPLESS ? 0 : 2);
    check("b2b_last", lerr, 0);
    sel = 1'b0;
    din_m = 8'hFF;
    dv_m = 1'b1;
    tick();
    dv_m = 1'b0;
`ifdef SERIAL_BIT_FEEDER_GAPLESS_EN
    tick();
`endif
    tick();
    tick();
    tick();
    check("ff_bit4", {y_m, yv_m, busy_m}, 3'b111);
    rst = 1'b0;
    #1;
    check("mid_rst", {y_m, yv_m, last_m, busy_m, rdy_m}, 5'b00001);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst", {y_m, yv_m, last_m, busy_m, rdy_m}, 5'b00001);
    stream(32'h0000_00A5, 1, 20, got, nbits, gaps, zcnt, zidx, lerr, nacc);
    check("a5_accepted", nacc, 1);
    check("a5_bits", got[7:0], 8'hA5);
    check("a5_nbits", nbits, 8);
    check("a5_last", lerr, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
